conv_window_gen: RTL and testbench

//  Streaming 3x3 window generator and producer side of the ConvolutionUnit image port.
//  - Accepts a raster-order pixel stream through a valid/ready handshake.
//  - Keeps the two previous image rows in internal line buffers.
//  - Emits one packed 72-bit 3x3 window per fully-interior pixel, in the same byte

---
 rtl/conv_window_gen.sv | 110 +++++++++++
 tb/tb_conv_window_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 window generator with two line buffers and one output register stage
module conv_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    output logic                 pix_ready,
    output logic [9*PIX_W-1:0]   win_data,
    output logic                 win_valid,
    output logic                 win_last,
    input  logic                 win_ready
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]      col_cnt;
    logic [RW-1:0]      row_cnt;
    logic [CW-1:0]      pos_c;
    logic [CW-1:0]      nxt_c;
    logic [RW-1:0]      pos_r;
    logic [RW-1:0]      nxt_r;
    logic               acc;
    logic               emit;
    logic               last_pos;

    // Line buffers hold rows r-2 (top) and r-1 (mid); no reset needed since
    // a window only ever uses entries rewritten in the current frame.
    logic [PIX_W-1:0]   lb_top [IMG_WIDTH];
    logic [PIX_W-1:0]   lb_mid [IMG_WIDTH];
    logic [PIX_W-1:0]   top_rd;
    logic [PIX_W-1:0]   mid_rd;

    // Each window row is {left, centre, right}; new pixels enter on the right.
    logic [3*PIX_W-1:0] row_top;
    logic [3*PIX_W-1:0] row_mid;
    logic [3*PIX_W-1:0] row_bot;
    logic [3*PIX_W-1:0] row_top_nxt;
    logic [3*PIX_W-1:0] row_mid_nxt;
    logic [3*PIX_W-1:0] row_bot_nxt;

    // A stalled output register blocks the input; otherwise one pixel per clock.
    assign pix_ready = ~win_valid | win_ready;
    assign acc       = pix_valid & pix_ready;

    // Pixel position, line-buffer read, shifted window and counter advance.
    always_comb begin
        pos_c       = pix_sof ? '0 : col_cnt;
        pos_r       = pix_sof ? '0 : row_cnt;
        top_rd      = lb_top[pos_c];
        mid_rd      = lb_mid[pos_c];
        row_top_nxt = {row_top[2*PIX_W-1:0], top_rd};
        row_mid_nxt = {row_mid[2*PIX_W-1:0], mid_rd};
        row_bot_nxt = {row_bot[2*PIX_W-1:0], pix_in};
        emit        = (pos_r >= RW'(2)) && (pos_c >= CW'(2));
        last_pos    = (pos_r == ROW_LAST) && (pos_c == COL_LAST);
        nxt_c       = pos_c + CW'(1);
        nxt_r       = pos_r;
        if (pos_c == COL_LAST) begin
            nxt_c = '0;
            nxt_r = (pos_r == ROW_LAST) ? '0 : pos_r + RW'(1);
        end
    end

    // Line buffers: top takes the old mid entry, mid takes the new pixel.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_top[pos_c] <= mid_rd;
            lb_mid[pos_c] <= pix_in;
        end
    end

    // Counters, window shift register and the output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            row_top   <= '0;
            row_mid   <= '0;
            row_bot   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
        end else begin
            if (acc) begin
                col_cnt <= nxt_c;
                row_cnt <= nxt_r;
                row_top <= row_top_nxt;
                row_mid <= row_mid_nxt;
                row_bot <= row_bot_nxt;
            end
            if (acc && emit) begin
                win_valid <= 1'b1;
                win_last  <= last_pos;
                win_data  <= {row_top_nxt, row_mid_nxt, row_bot_nxt};
            end else if (win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen (4x4 image, 8-bit pixels)
module tb_conv_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_last;
    logic        win_ready;

    conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_last  (win_last),
        .win_ready (win_ready)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [72:0] exp_q[$];
    logic [72:0] got[$];
    logic [7:0]  img[H][W];
    int          mr = 0;
    int          mc = 0;
    bit          acc_seen;
    logic [71:0] wins[4];

    typedef struct {
        logic [7:0]  pix;
        logic        sof;
        logic        vld;
        logic        exp_valid;
        logic        exp_last;
        logic [71:0] exp_data;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: the image is a plain 2D array; a window is the 3x3
    // block ending at the accepted pixel whenever that pixel is interior.
    task automatic model_accept(input logic [7:0] p, input logic s);
        logic [71:0] w;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            w = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                 img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                 img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
            exp_q.push_back({(mr == H-1 && mc == W-1), w});
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        exp_q.delete();
    endtask

    task automatic observe();
        logic [72:0] e;
        acc_seen = pix_valid && pix_ready;
        if (win_valid && win_ready) begin
            got.push_back({win_last, win_data});
            if (exp_q.size() == 0) chk("sb_extra_window", {win_last, win_data}, 73'h0);
            else begin
                e = exp_q.pop_front();
                chk("sb_window", {win_last, win_data}, e);
            end
        end
        if (acc_seen) model_accept(pix_in, pix_sof);
    endtask

    task automatic cyc();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] p, input logic s, input bit rnd);
        bit done = 1'b0;
        if (rnd && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            win_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        pix_in    = p;
        pix_sof   = s;
        pix_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            done = acc_seen;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!done) chk("feed_timeout", 73'h0, 73'h1);
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        win_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", 73'(exp_q.size()), 73'h0);
    endtask

    task automatic check_four(input string name);
        chk({name, "_count"}, 73'(got.size()), 73'h4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk({name, "_win"}, got[i], {(i == 3), wins[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wins[0] = 72'h010203_050607_090A0B;
        wins[1] = 72'h020304_060708_0A0B0C;
        wins[2] = 72'h050607_090A0B_0D0E0F;
        wins[3] = 72'h060708_0A0B0C_0E0F10;

        for (int i = 0; i < 17; i++) begin
            tbl[i].pix       = (i < 16) ? 8'(i + 1) : 8'h00;
            tbl[i].sof       = (i == 0);
            tbl[i].vld       = (i < 16);
            tbl[i].exp_valid = 1'b0;
            tbl[i].exp_last  = 1'b0;
            tbl[i].exp_data  = 72'h0;
        end
        tbl[11].exp_valid = 1'b1; tbl[11].exp_data = wins[0];
        tbl[12].exp_valid = 1'b1; tbl[12].exp_data = wins[1];
        tbl[15].exp_valid = 1'b1; tbl[15].exp_data = wins[2];
        tbl[16].exp_valid = 1'b1; tbl[16].exp_data = wins[3]; tbl[16].exp_last = 1'b1;

        // Reset state
        rst_n = 1'b0; pix_in = 8'h0; pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", 73'(win_valid), 73'h0);
        chk("rst_win_last", 73'(win_last), 73'h0);
        chk("rst_win_data", 73'(win_data), 73'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pix_ready", 73'(pix_ready), 73'h1);
        model_reset();

        // Table-driven frame 1..16, consumer always ready
        got.delete();
        for (int i = 0; i < 17; i++) begin
            pix_in = tbl[i].pix; pix_sof = tbl[i].sof; pix_valid = tbl[i].vld; win_ready = 1'b1;
            @(negedge clk);
            chk("tbl_valid", 73'(win_valid), 73'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk("tbl_data", 73'(win_data), 73'(tbl[i].exp_data));
                chk("tbl_last", 73'(win_last), 73'(tbl[i].exp_last));
            end
            observe();
            @(posedge clk);
            #1;
        end
        drain();
        check_four("tbl");

        // Back-pressure: consumer stalls 5 cycles on the first window
        got.delete();
        for (int i = 0; i < 11; i++) feed(8'(i + 1), (i == 0), 1'b0);
        win_ready = 1'b0; pix_in = 8'd12; pix_valid = 1'b1; pix_sof = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 73'(win_valid), 73'h1);
            chk("hold_pix_ready", 73'(pix_ready), 73'h0);
            chk("hold_data", 73'(win_data), 73'(wins[0]));
            observe();
            @(posedge clk);
            #1;
        end
        for (int i = 11; i < 16; i++) feed(8'(i + 1), 1'b0, 1'b0);
        drain();
        check_four("hold");

        // Two frames back-to-back
        got.delete();
        for (int i = 0; i < 16; i++) feed(8'(i + 1), (i == 0), 1'b0);
        for (int i = 0; i < 16; i++) feed(8'(8'h11 + i), (i == 0), 1'b0);
        drain();
        chk("b2b_count", 73'(got.size()), 73'h8);
        if (got.size() == 8) begin
            chk("b2b_f2_first", got[4], {1'b0, 72'h111213_151617_191A1B});
            chk("b2b_f1_last", 73'(got[3][72]), 73'h1);
            chk("b2b_f2_last", 73'(got[7][72]), 73'h1);
            chk("b2b_f2_notlast", 73'(got[6][72]), 73'h0);
        end

        // Mid-frame sof abandons the partial frame
        got.delete();
        for (int i = 0; i < 6; i++) feed(8'(i + 1), (i == 0), 1'b0);
        for (int i = 0; i < 16; i++) feed(8'(8'h20 + i), (i == 0), 1'b0);
        drain();
        chk("sof_count", 73'(got.size()), 73'h4);
        if (got.size() > 0) chk("sof_first", got[0], {1'b0, 72'h202122_242526_28292A});

        // Reset while a window is pending, then a fresh frame without sof
        for (int i = 0; i < 11; i++) feed(8'(i + 1), (i == 0), 1'b0);
        chk("prerst_valid", 73'(win_valid), 73'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 73'(win_valid), 73'h0);
        chk("midrst_last", 73'(win_last), 73'h0);
        chk("midrst_data", 73'(win_data), 73'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        for (int i = 0; i < 16; i++) feed(8'(i + 1), 1'b0, 1'b0);
        drain();
        check_four("postrst");

        // Randomized pixels, gaps, back-pressure and occasional mid-frame sof
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++)
                feed(8'($urandom_range(0, 255)), (i == 0) || ($urandom_range(0, 39) == 0), 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
